fetch_unit_pq: RTL and testbench

// - Parametrised instruction-fetch front end for the pipelined core: PC register, imem addressing, DEPTH-entry prefetch queue.
// - Decouples imem from decode through a valid/ready handshake, so decode stalls no longer freeze the PC.
// - Redirect input (branch/jump resolved in X) flushes all queued work and restarts fetch at the new PC.
// - Sits between imem and the F/D pipeline register.

---
 rtl/fetch_unit_pq_pkg.sv | 30 +++
 rtl/fetch_unit_pq_if.sv | 32 +++
 rtl/fetch_unit_pq_fetch_queue.sv | 63 ++++++
 rtl/fetch_unit_pq.sv | 101 ++++++++++
 tb/tb_fetch_unit_pq.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pq_pkg.sv
// Shared definitions for the fetch front end: opcode encodings, instruction
// field widths and small decode helpers used by next-PC prediction.
package fetch_unit_pq_pkg;

  localparam int OPC_W  = 5;
  localparam int IMM_W  = 17;
  localparam int JTGT_W = 27;

  localparam logic [OPC_W-1:0] OP_J    = 5'b00001;
  localparam logic [OPC_W-1:0] OP_BNE  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b00100;
  localparam logic [OPC_W-1:0] OP_BLT  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SW   = 5'b00111;
  localparam logic [OPC_W-1:0] OP_LW   = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01001;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Unconditional direct jumps whose target is the low 27 bits of the word.
  function automatic logic is_direct_jump(input logic [OPC_W-1:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

  // Conditional branches with a 17-bit signed PC-relative offset.
  function automatic logic is_cond_branch(input logic [OPC_W-1:0] op);
    return (op == OP_BNE) || (op == OP_BLT);
  endfunction

endpackage

// File: rtl/fetch_unit_pq_if.sv
// Bundle of the imem, redirect and decode-side signals of the fetch unit.
// Handshake: an entry moves to decode on a clock edge where dec_valid and
// dec_ready are both high; dec_valid never depends on dec_ready, and a
// redirect masks dec_valid in the same cycle so nothing is consumed then.
interface fetch_unit_pq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] address_imem;
  logic [DATA_W-1:0] q_imem;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_ready;
  logic              dec_valid;
  logic [DATA_W-1:0] dec_insn;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_pred_taken;
  logic [CNT_W-1:0]  q_count;

  modport slave (
    input  q_imem, redirect_valid, redirect_pc, dec_ready,
    output address_imem, dec_valid, dec_insn, dec_pc, dec_pred_taken, q_count
  );

  modport master (
    output q_imem, redirect_valid, redirect_pc, dec_ready,
    input  address_imem, dec_valid, dec_insn, dec_pc, dec_pred_taken, q_count
  );
endinterface

// File: rtl/fetch_unit_pq_fetch_queue.sv
// Circular prefetch FIFO. Pointers wrap naturally; full/empty come from the
// occupancy counter. Flush empties the queue and wins over enq/deq.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enq_i,
  input  logic [WIDTH-1:0]             enq_data_i,
  input  logic                         deq_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next pointer/count values; flush clears everything.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (enq_i) wr_d = wr_q + PTR_ONE;
      if (deq_i) rd_d = rd_q + PTR_ONE;
      if (enq_i && !deq_i)      cnt_d = cnt_q + CNT_ONE;
      else if (!enq_i && deq_i) cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; a full queue may be written at the slot being read this cycle.
  always_ff @(posedge clk_i) begin
    if (enq_i && !flush_i) mem_q[wr_q] <= enq_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit_pq.sv
// Instruction fetch front end: PC register, imem addressing and a prefetch
// queue decoupling imem from decode. A redirect flushes the queue and
// restarts fetch at redirect_pc.
// Optional feature macro: FETCH_BTFN_EN (static backward-taken/forward-not-
// taken and direct-jump prediction on the fetched word).
module fetch_unit_pq
  import fetch_unit_pq_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  fetch_unit_pq_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef FETCH_BTFN_EN
  localparam int ENTRY_W = ADDR_W + DATA_W + 1;
`else
  localparam int ENTRY_W = ADDR_W + DATA_W;
`endif
  localparam logic [ADDR_W-1:0] PC_STEP = 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  pc_q, pc_d, next_pc;
  logic [CNT_W-1:0]   count;
  logic               full, empty, deq, enq_ok, fetch;
  logic [ENTRY_W-1:0] enq_entry, head_entry;

  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign bus.dec_valid = !empty && !bus.redirect_valid;
  assign deq    = bus.dec_valid && bus.dec_ready;
  assign enq_ok = !full || deq;
  assign fetch  = enq_ok && !bus.redirect_valid;

`ifdef FETCH_BTFN_EN
  logic             pred;
  logic [OPC_W-1:0] opcode;
  assign opcode = bus.q_imem[31:27];

  // Static prediction: direct jumps and backward conditional branches taken.
  always_comb begin
    next_pc = pc_q + PC_STEP;
    pred    = 1'b0;
    if (is_direct_jump(opcode)) begin
      next_pc = ADDR_W'(bus.q_imem[JTGT_W-1:0]);
      pred    = 1'b1;
    end else if (is_cond_branch(opcode) && bus.q_imem[IMM_W-1]) begin
      next_pc = pc_q + PC_STEP
              + {{(ADDR_W-IMM_W){bus.q_imem[IMM_W-1]}}, bus.q_imem[IMM_W-1:0]};
      pred    = 1'b1;
    end
  end

  assign enq_entry = {pred, bus.address_imem, bus.q_imem};
  assign {bus.dec_pred_taken, bus.dec_pc, bus.dec_insn} = head_entry;
`else
  // Without prediction the fetch stream is purely sequential.
  always_comb begin
    next_pc = pc_q + PC_STEP;
  end

  assign enq_entry = {bus.address_imem, bus.q_imem};
  assign {bus.dec_pc, bus.dec_insn} = head_entry;
  assign bus.dec_pred_taken = 1'b0;
`endif

  // PC next-state: redirect beats fetch; otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) pc_d = bus.redirect_pc;
    else if (fetch)         pc_d = next_pc;
  end

  // PC register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign bus.address_imem = pc_q;
  assign bus.q_count      = count;

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i      (clock),
    .rst_i      (reset),
    .enq_i      (fetch),
    .enq_data_i (enq_entry),
    .deq_i      (deq),
    .flush_i    (bus.redirect_valid),
    .head_o     (head_entry),
    .count_o    (count)
  );

endmodule

// File: tb/tb_fetch_unit_pq.sv
// Directed bench for fetch_unit_pq: imem returns its own address except at
// one programmable address, decode readiness and redirects driven per test.
module tb_fetch_unit_pq;
  import fetch_unit_pq_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [ADDR_W-1:0] sp_addr = 32'hDEAD_0000;
  logic [DATA_W-1:0] sp_word = NOP_WORD;

  fetch_unit_pq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fetch_unit_pq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  // Clock.
  always #5 clk = ~clk;

  // imem model: word = address, except one planted instruction.
  always_comb begin
    bus.q_imem = bus.address_imem;
    if (bus.address_imem == sp_addr) bus.q_imem = sp_word;
  end

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.dec_ready = ready;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.dec_ready = 1'b0;
    #1;
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.dec_valid); end
    n_cmp++; if (bus.q_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.q_count); end
    n_cmp++; if (bus.address_imem !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.address_imem); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b want 0", bus.dec_valid); end
    @(negedge clk); #1;
    n_cmp++; if (bus.q_count !== 3'd1) begin n_fail++; $display("FAIL release_count: got %0d want 1", bus.q_count); end
    n_cmp++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h0) begin n_fail++; $display("FAIL release_head: got v=%b pc=%h want v=1 pc=0", bus.dec_valid, bus.dec_pc); end
    n_cmp++; if (bus.address_imem !== 32'h1) begin n_fail++; $display("FAIL release_pc: got %h want 1", bus.address_imem); end
  endtask

  task automatic test_throughput();
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (bus.dec_valid !== 1'b1 || bus.dec_insn !== 32'(k) || bus.dec_pc !== 32'(k)) begin
        n_fail++; $display("FAIL tput_%0d: got v=%b insn=%h pc=%h want v=1 insn=pc=%h", k, bus.dec_valid, bus.dec_insn, bus.dec_pc, k);
      end
      n_cmp++; if (bus.q_count !== 3'd1) begin n_fail++; $display("FAIL tput_count_%0d: got %0d want 1", k, bus.q_count); end
      n_cmp++; if (bus.address_imem !== 32'(k + 1)) begin n_fail++; $display("FAIL tput_pc_%0d: got %h want %h", k, bus.address_imem, k + 1); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (bus.q_count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", bus.q_count); end
    n_cmp++; if (bus.address_imem !== 32'h4) begin n_fail++; $display("FAIL bp_pc: got %h want 4", bus.address_imem); end
    bus.dec_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (bus.dec_valid !== 1'b1 || bus.dec_insn !== 32'(k)) begin
        n_fail++; $display("FAIL bp_drain_%0d: got v=%b insn=%h want v=1 insn=%h", k, bus.dec_valid, bus.dec_insn, k);
      end
      @(negedge clk); #1;
    end
    n_cmp++; if (bus.q_count !== 3'd4) begin n_fail++; $display("FAIL bp_full_deq_count: got %0d want 4", bus.q_count); end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.q_count !== 3'd3) begin n_fail++; $display("FAIL rd_pre_count: got %0d want 3", bus.q_count); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    #1;
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL rd_mask: got %b want 0", bus.dec_valid); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.dec_ready = 1'b1;
    #1;
    n_cmp++; if (bus.q_count !== 3'd0) begin n_fail++; $display("FAIL rd_t1_count: got %0d want 0", bus.q_count); end
    n_cmp++; if (bus.address_imem !== 32'h40) begin n_fail++; $display("FAIL rd_t1_pc: got %h want 40", bus.address_imem); end
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL rd_t1_valid: got %b want 0", bus.dec_valid); end
    @(negedge clk); #1;
    n_cmp++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h40 || bus.dec_insn !== 32'h40) begin
      n_fail++; $display("FAIL rd_t2_head: got v=%b pc=%h insn=%h want v=1 pc=insn=40", bus.dec_valid, bus.dec_pc, bus.dec_insn);
    end
    @(negedge clk); #1;
    n_cmp++; if (bus.dec_pc !== 32'h41) begin n_fail++; $display("FAIL rd_t3_head: got %h want 41", bus.dec_pc); end
  endtask

  task automatic test_priority();
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    #1;
    n_cmp++; if (bus.q_count !== 3'd4) begin n_fail++; $display("FAIL pri_full: got %0d want 4", bus.q_count); end
    bus.dec_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h80;
    #1;
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL pri_valid: got %b want 0", bus.dec_valid); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.dec_ready = 1'b0;
    #1;
    n_cmp++; if (bus.q_count !== 3'd0 || bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL pri_empty: got cnt=%0d v=%b want cnt=0 v=0", bus.q_count, bus.dec_valid); end
    @(negedge clk); #1;
    n_cmp++; if (bus.q_count !== 3'd1 || bus.dec_pc !== 32'h80) begin n_fail++; $display("FAIL pri_refill: got cnt=%0d pc=%h want cnt=1 pc=80", bus.q_count, bus.dec_pc); end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    repeat (2) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    @(negedge clk);
    bus.redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    n_cmp++; if (bus.address_imem !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_pc: got %h want ffffffff", bus.address_imem); end
    @(negedge clk); #1;
    n_cmp++; if (bus.dec_pc !== 32'hFFFF_FFFF || bus.address_imem !== 32'h0) begin
      n_fail++; $display("FAIL b2b_wrap: got head=%h pc=%h want head=ffffffff pc=0", bus.dec_pc, bus.address_imem);
    end
    @(negedge clk); #1;
    n_cmp++; if (bus.dec_pc !== 32'h0 || bus.dec_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_after_wrap: got v=%b head=%h want v=1 head=0", bus.dec_valid, bus.dec_pc); end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", bus.dec_valid); end
    n_cmp++; if (bus.q_count !== 3'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", bus.q_count); end
    n_cmp++; if (bus.address_imem !== 32'h0) begin n_fail++; $display("FAIL ar_pc: got %h want 0", bus.address_imem); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Redirect to PC 10 where the planted word sits; check the fetch after it.
  task automatic run_btfn(input string name, input logic [31:0] word,
                          input logic [31:0] exp_next, input logic exp_pred);
    do_reset(1'b1);
    sp_addr = 32'd10;
    sp_word = word;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd10;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus.dec_pc !== 32'd10 || bus.dec_insn !== word) begin
      n_fail++; $display("FAIL %s_head: got pc=%h insn=%h want pc=a insn=%h", name, bus.dec_pc, bus.dec_insn, word);
    end
    n_cmp++; if (bus.address_imem !== exp_next) begin n_fail++; $display("FAIL %s_next: got %h want %h", name, bus.address_imem, exp_next); end
    n_cmp++; if (bus.dec_pred_taken !== exp_pred) begin n_fail++; $display("FAIL %s_pred: got %b want %b", name, bus.dec_pred_taken, exp_pred); end
    sp_addr = 32'hDEAD_0000;
  endtask

  task automatic test_btfn();
`ifdef FETCH_BTFN_EN
    run_btfn("bne_back", 32'h1001_FFFC, 32'd7,     1'b1);
    run_btfn("bne_fwd",  32'h1000_0004, 32'd11,    1'b0);
    run_btfn("jal",      32'h1800_0200, 32'h200,   1'b1);
`else
    run_btfn("bne_back", 32'h1001_FFFC, 32'd11,    1'b0);
    run_btfn("bne_fwd",  32'h1000_0004, 32'd11,    1'b0);
    run_btfn("jal",      32'h1800_0200, 32'd11,    1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_backpressure();
    test_redirect();
    test_priority();
    test_back_to_back();
    test_async_reset();
    test_btfn();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
